// File: rtl/exibe_pkg.sv
// exibe_pkg: state codes and default widths shared by the sequence presentation engine.
package exibe_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        CARREGA = 4'h1,
        ACESO   = 4'h2,
        APAGADO = 4'h3,
        FIM     = 4'hF
    } estado_t;
endpackage

// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia_if: control/memory/display signals between the game and the presentation engine.
interface exibe_sequencia_if
    import exibe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              iniciar_exibicao;
    logic [ADDR_W-1:0] limite;
    logic [DATA_W-1:0] dado;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              exibindo;
    logic              fim_exibicao;
    logic [3:0]        db_estado;
    modport master (
        output iniciar_exibicao, limite, dado,
        input  endereco, leds, exibindo, fim_exibicao, db_estado
    );
    modport slave (
        input  iniciar_exibicao, limite, dado,
        output endereco, leds, exibindo, fim_exibicao, db_estado
    );
endinterface

// File: rtl/exibe_sequencia_contador_tempo.sv
// contador_tempo: clearable up-counter with terminal flag against a runtime limit.
module contador_tempo #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_lim,
    output logic         o_tc
);
    logic [W-1:0] r_cont;
    always_ff @(posedge clock or posedge reset)
        if (reset) r_cont <= '0;
        else r_cont <= i_clr ? '0 : i_en ? r_cont + 1'b1 : r_cont;
    assign o_tc = r_cont == i_lim;
endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: replays memory entries 0..limite on the leds, each lit T_ACESO cycles
// followed by T_APAGADO dark cycles, then pulses fim_exibicao.
module exibe_sequencia
    import exibe_pkg::*;
#(
    parameter int T_ACESO   = 3,
    parameter int T_APAGADO = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input logic              clock,
    input logic              reset,
    exibe_sequencia_if.slave bus
);
    localparam int TW = $clog2(T_ACESO > T_APAGADO ? T_ACESO : T_APAGADO) + 1;
    estado_t           r_estado, w_prox;
    logic [ADDR_W-1:0] r_endereco, r_limite;
    logic [DATA_W-1:0] r_leds;
    logic              w_fase, w_tc, w_ultimo;
    logic [TW-1:0]     w_lim;
    assign w_fase   = r_estado == ACESO || r_estado == APAGADO;
    assign w_lim    = r_estado == ACESO ? TW'(T_ACESO - 1) : TW'(T_APAGADO - 1);
    assign w_ultimo = r_endereco == r_limite;
    contador_tempo #(.W(TW)) u_tempo (
        .clock (clock),
        .reset (reset),
        .i_clr (!w_fase || w_tc),
        .i_en  (w_fase),
        .i_lim (w_lim),
        .o_tc  (w_tc)
    );
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL: w_prox = bus.iniciar_exibicao ? CARREGA : INICIAL;
            CARREGA: w_prox = ACESO;
            ACESO:   w_prox = w_tc ? APAGADO : ACESO;
            APAGADO: w_prox = !w_tc ? APAGADO : w_ultimo ? FIM : CARREGA;
            default: w_prox = INICIAL;
        endcase
    end
    // Compare precedes increment, so the last address is never followed by a wrap.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            r_estado   <= INICIAL;
            r_endereco <= '0;
            r_leds     <= '0;
            r_limite   <= '0;
        end else begin
            r_estado   <= w_prox;
            r_limite   <= (r_estado == INICIAL && bus.iniciar_exibicao) ? bus.limite : r_limite;
            r_leds     <= r_estado == CARREGA ? bus.dado :
                          (r_estado == INICIAL || (r_estado == ACESO && w_tc)) ? '0 : r_leds;
            r_endereco <= r_estado == FIM ? '0 :
                          (r_estado == APAGADO && w_tc && !w_ultimo) ? r_endereco + 1'b1 : r_endereco;
        end
    assign bus.endereco     = r_endereco;
    assign bus.leds         = r_leds;
    assign bus.exibindo     = r_estado == CARREGA || w_fase;
    assign bus.fim_exibicao = r_estado == FIM;
    assign bus.db_estado    = r_estado;
endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia: directed cycle-by-cycle checks of the presentation engine with a 1,2,4,8 ROM.
module tb_exibe_sequencia;
    logic clock = 0;
    logic reset = 1;
    int total = 0;
    int bad = 0;
    exibe_sequencia_if #(.ADDR_W(4), .DATA_W(4)) bus ();
    exibe_sequencia #(.T_ACESO(3), .T_APAGADO(2), .ADDR_W(4), .DATA_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    function automatic logic [3:0] rom(input logic [3:0] a);
        rom = 4'b0001 << a[1:0];
    endfunction
    assign bus.dado = rom(bus.endereco);
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic start(input logic [3:0] lim);
        @(negedge clock);
        bus.limite = lim;
        bus.iniciar_exibicao = 1;
        tick();
        bus.iniciar_exibicao = 0;
    endtask
    // Cycle c is the cycle after start edge + (c-1) edges; each entry takes 6 cycles.
    task automatic run(input int lim, input int last, input bit poke);
        for (int c = 1; c <= last; c++) begin
            int k;
            logic [3:0] xl, xs, xa;
            logic xx, xf;
            k = c - 1;
            if (k == (lim + 1) * 6) begin
                xs = 4'hF; xl = 0; xa = 4'(lim); xx = 0; xf = 1;
            end else if (k > (lim + 1) * 6) begin
                xs = 0; xl = 0; xa = 0; xx = 0; xf = 0;
            end else begin
                xa = 4'(k / 6);
                xs = (k % 6 == 0) ? 4'h1 : (k % 6 < 4) ? 4'h2 : 4'h3;
                xl = (k % 6 >= 1 && k % 6 <= 3) ? rom(xa) : 4'h0;
                xx = 1; xf = 0;
            end
            chk($sformatf("L%0d c%0d leds", lim, c), bus.leds, xl);
            chk($sformatf("L%0d c%0d endereco", lim, c), bus.endereco, xa);
            chk($sformatf("L%0d c%0d exibindo", lim, c), bus.exibindo, xx);
            chk($sformatf("L%0d c%0d fim", lim, c), bus.fim_exibicao, xf);
            chk($sformatf("L%0d c%0d estado", lim, c), bus.db_estado, xs);
            if (poke && c == 6) begin
                bus.iniciar_exibicao = 1;
                bus.limite = 5;
            end
            tick();
            bus.iniciar_exibicao = 0;
        end
    endtask
    initial begin
        bus.iniciar_exibicao = 0;
        bus.limite = 0;
        #12;
        chk("rst_hold leds", bus.leds, 0);
        chk("rst_hold estado", bus.db_estado, 0);
        @(negedge clock);
        reset = 0;
        tick();
        chk("rst leds", bus.leds, 0);
        chk("rst endereco", bus.endereco, 0);
        chk("rst exibindo", bus.exibindo, 0);
        chk("rst fim", bus.fim_exibicao, 0);
        chk("rst estado", bus.db_estado, 0);
        start(0);
        run(0, 8, 0);
        start(2);
        run(2, 20, 0);
        start(2);
        run(2, 20, 1);
        start(15);
        run(15, 98, 0);
        start(1);
        repeat (8) tick();
        chk("pre_arst leds", bus.leds, 4'h2);
        chk("pre_arst endereco", bus.endereco, 1);
        reset = 1;
        #1;
        chk("arst leds", bus.leds, 0);
        chk("arst estado", bus.db_estado, 0);
        chk("arst endereco", bus.endereco, 0);
        chk("arst exibindo", bus.exibindo, 0);
        @(negedge clock);
        reset = 0;
        start(0);
        run(0, 8, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
